// File: rtl/apb_bridge_pkg.sv
// Shared types and field positions for the ICB-to-APB bridge.
// Used by the APB master controller and its slave-return multiplexer.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  // Command word (write FIFO) field positions.
  localparam int CMD_WRITE_BIT = 63;
  localparam int CMD_IDX_HI    = 62;
  localparam int CMD_IDX_LO    = 61;
  localparam int CMD_ADDR_HI   = 39;
  localparam int CMD_ADDR_LO   = 32;
  localparam int CMD_DATA_HI   = 31;
  localparam int CMD_DATA_LO   = 0;
  localparam int CMD_ADDR_W    = CMD_ADDR_HI - CMD_ADDR_LO + 1;
  localparam int CMD_DATA_W    = CMD_DATA_HI - CMD_DATA_LO + 1;

  // Response word (read FIFO) field positions.
  localparam int RSP_ERR_BIT = 40;
  localparam int WORD_W      = 64;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic                  write;
    logic [1:0]            idx;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

  function automatic logic [WORD_W-1:0] pack_rsp(input logic                  err,
                                                 input logic [CMD_ADDR_W-1:0] addr,
                                                 input logic [CMD_DATA_W-1:0] data);
    return {{(WORD_W - RSP_ERR_BIT - 1){1'b0}}, err, addr, data};
  endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// Selects the addressed slave's prdata/pready/pslverr; flags indices with no slave.
// Out-of-range indices return all-zero data, no ready and no error.
module apb_slv_mux #(
  parameter int NSLV   = 4,
  parameter int DATA_W = 32
) (
  input  logic [1:0]             idx,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr,
  output logic [DATA_W-1:0]      sel_prdata,
  output logic                   sel_pready,
  output logic                   sel_pslverr,
  output logic                   idx_oor
);

  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    sel_prdata  = '0;
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    idx_oor     = 1'b1;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == 2'(i)) begin
        sel_prdata  = prdata[i*DATA_W +: DATA_W];
        sel_pready  = pready[i];
        sel_pslverr = pslverr[i];
        idx_oor     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: pops command words, runs one APB transfer each, pushes read responses.
// Reads only start when the read FIFO has room, so the completion push never overflows.
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wfifo_empty,
  input  logic [WORD_W-1:0]      wfifo_rdata,
  output logic                   wfifo_ren,
  input  logic                   rfifo_full,
  output logic [WORD_W-1:0]      rfifo_wdata,
  output logic                   rfifo_wen,
  output logic [1:0]             apb_state,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr,
  output logic [7:0]             err_cnt
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  apb_state_e             state_q, state_d;
  cmd_t                   cmd_q, cmd_in;
  logic [7:0]             cnt_q;
  logic [7:0]             err_cnt_q;
  logic [WORD_W-1:0]      rsp_q;
  logic                   rsp_wen_q;
  logic                   pop, done, timed_out, xfer_err;
  logic [DATA_W-1:0]      sel_prdata;
  logic                   sel_pready, sel_pslverr, idx_oor;
  logic [CMD_DATA_W-1:0]  rsp_data;
  logic                   unused_cmd_bits;

  assign cmd_in = '{write: wfifo_rdata[CMD_WRITE_BIT],
                    idx:   wfifo_rdata[CMD_IDX_HI:CMD_IDX_LO],
                    addr:  wfifo_rdata[CMD_ADDR_HI:CMD_ADDR_LO],
                    data:  wfifo_rdata[CMD_DATA_HI:CMD_DATA_LO]};
  assign unused_cmd_bits = ^wfifo_rdata[CMD_IDX_LO-1:CMD_ADDR_HI+1];

  apb_slv_mux #(
    .NSLV   (NSLV),
    .DATA_W (DATA_W)
  ) u_slv_mux (
    .idx         (cmd_q.idx),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .sel_prdata  (sel_prdata),
    .sel_pready  (sel_pready),
    .sel_pslverr (sel_pslverr),
    .idx_oor     (idx_oor)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Pop is gated by rst so a word is never consumed and then lost to the reset edge.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    xfer_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && en && !wfifo_empty && (cmd_in.write || !rfifo_full)) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // A real pready wins over a coincident timeout.
        timed_out = !idx_oor && !sel_pready && (cnt_q == TIMEOUT_C);
        done      = idx_oor || sel_pready || timed_out;
        xfer_err  = idx_oor || timed_out || sel_pslverr;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_data = (idx_oor || timed_out) ? '0 : CMD_DATA_W'(sel_prdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      rsp_q     <= '0;
      rsp_wen_q <= 1'b0;
    end else begin
      if (pop) cmd_q <= cmd_in;
      if (state_q == ACCESS && !done) cnt_q <= cnt_q + 8'd1;
      else                            cnt_q <= '0;
      rsp_wen_q <= done && !cmd_q.write;
      if (done && !cmd_q.write) rsp_q <= pack_rsp(xfer_err, cmd_q.addr, rsp_data);
      if (done && xfer_err && err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    psel = '0;
    for (int i = 0; i < NSLV; i++) begin
      psel[i] = (state_q == SETUP || state_q == ACCESS) && !idx_oor && (cmd_q.idx == 2'(i));
    end
  end

  assign penable     = (state_q == ACCESS);
  assign pwrite      = cmd_q.write;
  assign paddr       = ADDR_W'(cmd_q.addr);
  assign pwdata      = DATA_W'(cmd_q.data);
  assign wfifo_ren   = pop;
  assign rfifo_wen   = rsp_wen_q;
  assign rfifo_wdata = rsp_q;
  assign apb_state   = state_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Downstream stage of icb_slave in the ICB-to-APB bridge.
- Pops command words from the write FIFO that icb_slave fills and runs one APB transfer per word to one of NSLV APB slaves.
- For read commands, pushes the returned data and status into the read FIFO that icb_slave drains.
- Drives apb_state, which icb_slave exposes as status.

Parameters:
- NSLV, 4, number of APB slaves (1..4); psel is one-hot over these.
- ADDR_W, 8, APB register address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 255, maximum ACCESS cycles waiting for pready before forced completion.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  transfer enable (control[0] from icb_slave).
- wfifo_empty  in  1  write FIFO empty.
- wfifo_rdata  in  64  write FIFO head word (show-ahead).
- wfifo_ren  out  1  pop write FIFO.
- rfifo_full  in  1  read FIFO full.
- rfifo_wdata  out  64  read FIFO push word.
- rfifo_wen  out  1  push read FIFO.
- apb_state  out  2  FSM state.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  NSLV*DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W].
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.
- err_cnt  out  8  saturating count of errored or timed-out transfers.

Behaviour:
- Command word format:
  - [63] write = 1, read = 0.
  - [62:61] slave index.
  - [39:32] address.
  - [31:0] write data.
  - All other bits are ignored.
- Response word format:
  - [40] error.
  - [39:32] address.
  - [31:0] read data.
  - [63:41] are 0.
- Reset values: all outputs 0; apb_state = IDLE; internal command register and timeout counter cleared.
- State encoding: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10. 2'b11 is illegal and recovers to IDLE.
- IDLE -> SETUP when en && !wfifo_empty && (write || !rfifo_full). That cycle, wfifo_ren = 1 for exactly one cycle and the head word is latched.
  - A read is never started without read-FIFO space. Only this block pushes, so the reserved slot is guaranteed at completion.
- SETUP: psel[idx] = 1, penable = 0; paddr, pwrite and pwdata driven from the latched word. Always moves to ACCESS next cycle.
- ACCESS: psel held, penable = 1; counter increments each cycle.
  - Completes on pready[idx] or when counter == TIMEOUT.
  - Timeout error = 1, read data = 0.
  - Otherwise error = pslverr[idx], data = prdata[idx].
  - On completion, next state is IDLE; psel and penable drop on the same edge.
- Read completion: rfifo_wen = 1 for one cycle, registered, in the cycle after the completing ACCESS cycle, carrying the response word. Writes never push.
- Any errored completion increments err_cnt, saturating at 255.
- Slave index >= NSLV: no psel bit is asserted; the transfer completes in the first ACCESS cycle with error = 1 (reads push data 0).
- Addresses, data and control are stable through SETUP and ACCESS, per APB.
- Throughput: minimum 3 cycles per transfer (IDLE, SETUP, ACCESS); there is no back-to-back SETUP.
- en deasserted mid-transfer: the current transfer completes normally; no new pop.
- rst mid-transfer: psel, penable, rfifo_wen and apb_state are cleared at that edge. The popped command is discarded without a response; err_cnt clears.
- pready on a non-selected slave is ignored.

Decomposition:
- Package apb_bridge_pkg:
  - apb_state_e enum (IDLE, SETUP, ACCESS).
  - Command and response bit-field position constants.
  - Default ADDR_W and DATA_W.
- One sub-module, apb_slv_mux: combinational selection of prdata, pready and pslverr by index, with an out-of-range flag.
- FSM, counter and response register stay in the top.

Test Plan:
- Write: wfifo_rdata = 64'h8000_0012_DEAD_BEEF, slave 0 pready tied high.
  -> wfifo_ren pulses once; SETUP with psel = 4'b0001, paddr = 8'h12, pwrite = 1, pwdata = 32'hDEADBEEF.
  -> penable next cycle; back to IDLE; no rfifo_wen.
- Read with wait states: word 64'h2000_0034_0000_0000 (slave 1, addr 8'h34), pready[1] low for 3 cycles, prdata = 32'h0000_0005.
  -> ACCESS lasts 4 cycles; rfifo_wdata = 64'h0000_0034_0000_0005; one rfifo_wen pulse.
- Read while rfifo_full = 1.
  -> wfifo_ren stays 0 and apb_state stays IDLE.
  -> Release full: the transfer starts the next cycle.
- Timeout with TIMEOUT = 4: selected pready stuck low.
  -> Completion after counter reaches 4; response bit[40] = 1, data 0; err_cnt = 1.
- Error paths: pslverr high on completion of a write -> err_cnt increments. Index 3 with NSLV = 3 -> psel = 0, error response.
- rst asserted during ACCESS.
  -> Next edge: psel = 0, penable = 0, apb_state = IDLE, no rfifo_wen.
  -> Four queued writes then drain in order, each 3 cycles apart.
